// File: rtl/commit_trace_buffer_if.sv
// Commit/trace bundle for commit_trace_buffer.
// The master side is the buffer itself: it consumes the core's commit signals
// and the sink's ready, and produces the trace stream. The slave side is the
// surrounding environment (core commit port plus trace sink).
interface commit_trace_buffer_if;
    // Core commit port
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        commit_wr_en;
    logic [4:0]  commit_wr_reg;
    logic [31:0] commit_wr_data;
    logic [31:0] commit_v0;

    // Trace stream toward the checker/logger
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic        trace_wr_en;
    logic [4:0]  trace_wr_reg;
    logic [31:0] trace_wr_data;
    logic [15:0] trace_seq;

    modport master (
        input  commit_valid, commit_pc, commit_instr, commit_wr_en,
               commit_wr_reg, commit_wr_data, commit_v0, trace_ready,
        output trace_valid, trace_pc, trace_instr, trace_wr_en,
               trace_wr_reg, trace_wr_data, trace_seq
    );

    modport slave (
        output commit_valid, commit_pc, commit_instr, commit_wr_en,
               commit_wr_reg, commit_wr_data, commit_v0, trace_ready,
        input  trace_valid, trace_pc, trace_instr, trace_wr_en,
               trace_wr_reg, trace_wr_data, trace_seq
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures one retire record per committed instruction
// into a DEPTH-entry FIFO and streams it to a trace sink over valid/ready.
// Detects the end-of-test syscall ($v0 == 10), drains the FIFO and raises a
// sticky done flag. Full pushes are dropped and flagged by sticky overflow.
// Optional feature macro: TRACE_SEQ_EN adds a 16-bit per-record sequence
// number on trace_seq; without it trace_seq is tied to zero.
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    commit_trace_buffer_if.master  bus,
    output logic                   stall_req,
    output logic                   overflow,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_COUNT = CW'(DEPTH - 1);
    localparam logic [31:0]   SYSCALL     = 32'h0000_000C;
    localparam logic [31:0]   EXIT_CODE   = 32'h0000_000A;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [31:0] wr_data;
    } rec_t;

    state_t        state;
    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          trace_valid_q;

    logic          push_req;
    logic          push_ok;
    logic          drop;
    logic          pop;
    logic          full;
    logic          exit_hit;
    logic          rec_wr_en;
    rec_t          new_rec;
    rec_t          head;

    // Writes to $0 are architecturally discarded, so they are recorded as no-write
    assign rec_wr_en = bus.commit_wr_en && (bus.commit_wr_reg != 5'd0);
    assign new_rec   = '{pc:      bus.commit_pc,
                         instr:   bus.commit_instr,
                         wr_en:   rec_wr_en,
                         wr_reg:  rec_wr_en ? bus.commit_wr_reg  : 5'd0,
                         wr_data: rec_wr_en ? bus.commit_wr_data : 32'd0};

    assign push_req = (state == ST_RUN) && bus.commit_valid;
    assign exit_hit = push_req && (bus.commit_instr == SYSCALL)
                               && (bus.commit_v0 == EXIT_CODE);
    assign full     = (count == FULL_COUNT);
    assign pop      = trace_valid_q && bus.trace_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Next occupancy from the push/pop pair
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Record storage write; pointers alone define which entries are live
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; head outputs are masked by trace_valid instead.
        if (push_ok) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // Pointers, occupancy, sticky flags and the RUN/DRAIN/DONE sequencer
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state         <= ST_RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            trace_valid_q <= 1'b0;
            overflow      <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count         <= count_next;
            trace_valid_q <= (count_next != '0);
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (exit_hit) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign stall_req = (count >= STALL_COUNT);

    // Head record straight from storage, zeroed while the FIFO is empty
    assign head              = mem[rd_ptr];
    assign bus.trace_valid   = trace_valid_q;
    assign bus.trace_pc      = trace_valid_q ? head.pc      : 32'd0;
    assign bus.trace_instr   = trace_valid_q ? head.instr   : 32'd0;
    assign bus.trace_wr_en   = trace_valid_q ? head.wr_en   : 1'b0;
    assign bus.trace_wr_reg  = trace_valid_q ? head.wr_reg  : 5'd0;
    assign bus.trace_wr_data = trace_valid_q ? head.wr_data : 32'd0;

`ifdef TRACE_SEQ_EN
    logic [15:0] seq;
    logic [15:0] seq_mem [DEPTH];

    // Sequence counter advances on every accepted commit, pushed or dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= 16'd0;
        end else if (push_req) begin
            seq <= seq + 16'd1;
        end
    end

    // Per-entry sequence storage, written alongside the record
    always_ff @(posedge clk) begin
        if (push_ok) begin
            seq_mem[wr_ptr] <= seq;
        end
    end

    assign bus.trace_seq = trace_valid_q ? seq_mem[rd_ptr] : 16'd0;
`else
    assign bus.trace_seq = 16'd0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios followed by
// a randomized phase, all compared every cycle against a queue-based model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [31:0] wr_data;
        logic [15:0] seq;
    } trec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_req;
    logic       overflow;
    logic       done;
    logic [3:0] count;

    commit_trace_buffer_if bus ();

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_req (stall_req),
        .overflow  (overflow),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference model state
    trec_t       q[$];
    logic [15:0] m_seq;
    bit          m_exited;
    bit          m_done;
    bit          m_ovf;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic en, input logic [4:0] rg, input logic [31:0] data,
                         input logic [31:0] v0);
        bus.commit_valid   = v;
        bus.commit_pc      = pc;
        bus.commit_instr   = instr;
        bus.commit_wr_en   = en;
        bus.commit_wr_reg  = rg;
        bus.commit_wr_data = data;
        bus.commit_v0      = v0;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Compare every observable output against the model
    task automatic check_all();
        trec_t       h;
        logic [15:0] exp_seq;
        h = '{pc: 32'd0, instr: 32'd0, wr_en: 1'b0, wr_reg: 5'd0, wr_data: 32'd0, seq: 16'd0};
        if (q.size() != 0) h = q[0];
`ifdef TRACE_SEQ_EN
        exp_seq = h.seq;
`else
        exp_seq = 16'd0;
`endif
        chk("trace_valid",   32'(bus.trace_valid),   32'(q.size() != 0));
        chk("trace_pc",      bus.trace_pc,           h.pc);
        chk("trace_instr",   bus.trace_instr,        h.instr);
        chk("trace_wr_en",   32'(bus.trace_wr_en),   32'(h.wr_en));
        chk("trace_wr_reg",  32'(bus.trace_wr_reg),  32'(h.wr_reg));
        chk("trace_wr_data", bus.trace_wr_data,      h.wr_data);
        chk("trace_seq",     32'(bus.trace_seq),     32'(exp_seq));
        chk("count",         32'(count),             32'(q.size()));
        chk("stall_req",     32'(stall_req),         32'(q.size() >= DEPTH - 1));
        chk("overflow",      32'(overflow),          32'(m_ovf));
        chk("done",          32'(done),              32'(m_done));
    endtask

    // One clock: model consumes the driven inputs at the edge, then outputs are checked
    task automatic cycle();
        trec_t r;
        bit    do_pop;
        bit    do_push;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_seq    = 16'd0;
            m_exited = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            do_pop  = (q.size() != 0) && bus.trace_ready;
            do_push = 1'b0;
            if (!m_exited) begin
                if (bus.commit_valid) begin
                    r.pc      = bus.commit_pc;
                    r.instr   = bus.commit_instr;
                    r.wr_en   = bus.commit_wr_en && (bus.commit_wr_reg != 5'd0);
                    r.wr_reg  = r.wr_en ? bus.commit_wr_reg : 5'd0;
                    r.wr_data = r.wr_en ? bus.commit_wr_data : 32'd0;
                    r.seq     = m_seq;
                    m_seq     = m_seq + 16'd1;
                    if (q.size() == DEPTH && !do_pop) m_ovf = 1'b1;
                    else do_push = 1'b1;
                    if (bus.commit_instr == 32'h0000000C && bus.commit_v0 == 32'h0000000A)
                        m_exited = 1'b1;
                end
            end else if (!m_done && q.size() == 0) begin
                m_done = 1'b1;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.trace_ready = 1'b0;
        idle();
        q.delete();
        m_seq = 0; m_exited = 0; m_done = 0; m_ovf = 0;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Three in-order commits with the sink always ready
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0000_0021 + 32'(i), 1'b1, 5'(i + 8), 32'hA000_0000 + 32'(i), 32'd0);
            cycle();
        end
        idle();
        cycle();
        cycle();

        // addu targeting $0 is recorded as a non-write
        drive(1'b1, 32'h0000_0010, 32'h0000_0021, 1'b1, 5'd0, 32'h0000_1234, 32'd0);
        cycle();
        chk("zero_reg_wr_en", 32'(bus.trace_wr_en), 32'd0);
        chk("zero_reg_data",  bus.trace_wr_data,    32'd0);
        idle();
        cycle();

        // Fill with the sink stalled: ninth commit is dropped
        do_reset();
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h0040_0000 + 32'(i * 4), 32'h2408_0000 + 32'(i), 1'b1, 5'd9, 32'(i), 32'd0);
            cycle();
            if (i == 6) chk("stall_at_7", 32'(stall_req), 32'd1);
        end
        chk("ovf_after_9", 32'(overflow), 32'd1);
        chk("count_full",  32'(count),    32'd8);
        idle();
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        drive(1'b1, 32'h0040_0100, 32'h2408_00FF, 1'b1, 5'd10, 32'h55, 32'd0);
        cycle();
        idle();
        cycle();
        cycle();

        // Full FIFO with a simultaneous pop accepts the push
        do_reset();
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'h3C01_0000 + 32'(i), 1'b1, 5'd1, 32'(i + 100), 32'd0);
            cycle();
        end
        bus.trace_ready = 1'b1;
        drive(1'b1, 32'h200, 32'h3C01_1111, 1'b1, 5'd1, 32'h777, 32'd0);
        cycle();
        chk("full_pushpop_count", 32'(count),    32'd8);
        chk("full_pushpop_ovf",   32'(overflow), 32'd0);
        idle();
        for (int i = 0; i < 9; i++) cycle();

        // End-of-test syscall with two records already queued
        do_reset();
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 32'h0000_0021, 1'b1, 5'd3, 32'(i), 32'd0);
            cycle();
        end
        bus.trace_ready = 1'b1;
        drive(1'b1, 32'h308, 32'h0000_000C, 1'b0, 5'd0, 32'd0, 32'h0000_000A);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h400 + 32'(i * 4), 32'h0000_0021, 1'b1, 5'd4, 32'(i), 32'd0);
            cycle();
        end
        chk("done_after_drain", 32'(done),  32'd1);
        chk("ignored_commits",  32'(count), 32'd0);

        // Reset in the middle of DRAIN with four entries queued
        do_reset();
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 32'h0000_0021, 1'b1, 5'd5, 32'(i), 32'd0);
            cycle();
        end
        drive(1'b1, 32'h50C, 32'h0000_000C, 1'b0, 5'd0, 32'd0, 32'h0000_000A);
        cycle();
        idle();
        cycle();
        do_reset();
        chk("midrain_valid", 32'(bus.trace_valid), 32'd0);
        chk("midrain_count", 32'(count),           32'd0);
        chk("midrain_done",  32'(done),            32'd0);
        drive(1'b1, 32'h600, 32'h0000_0021, 1'b1, 5'd6, 32'h66, 32'd0);
        cycle();
        idle();
        bus.trace_ready = 1'b1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (m_done || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                bus.trace_ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 49) == 0)
                    drive(1'b1, $urandom, 32'h0000_000C, 1'b0, 5'd0, $urandom, 32'h0000_000A);
                else
                    drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 3) == 0) ? 32'h0000_000A : $urandom);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
